// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters, the round-robin arbiter and the regfile write port.
// Requester fields are packed flat, with requester i at slice i.
interface regfile_wb_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic                   wb_stall;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic [ID_W-1:0]        grant_id;
  logic                   busy;

  modport slave (
    input  req_valid, req_addr, req_data, wb_stall,
    output req_ready, wr_en, wr_addr, wr_data, grant_id, busy
  );

  modport master (
    output req_valid, req_addr, req_data, wb_stall,
    input  req_ready, wr_en, wr_addr, wr_data, grant_id, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one regfile write port among NREQ writeback requesters,
// with a single registered output stage that back-pressures on wb_stall.
module regfile_wb_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic              stage_vld_q, stage_vld_d;
  logic [ADDR_W-1:0] stage_addr_q, stage_addr_d;
  logic [DATA_W-1:0] stage_data_q, stage_data_d;
  logic [ID_W-1:0]   stage_id_q, stage_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic              win_found_s;
  logic [ID_W-1:0]   win_id_s;
  logic [ID_W-1:0]   scan_idx_s;
  logic              can_accept_s;
  logic              drain_s;
  logic              xfer_s;
  logic [NREQ-1:0]   ready_s;

  assign can_accept_s = ~stage_vld_q | ~bus.wb_stall;
  assign drain_s      = stage_vld_q & ~bus.wb_stall;
  assign xfer_s       = win_found_s & can_accept_s & ~reset;

  // Round-robin scan starting at rr_ptr: first valid requester wins.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    scan_idx_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx_s = ID_W'((int'(rr_ptr_q) + k) % NREQ);
      if (!win_found_s && bus.req_valid[scan_idx_s]) begin
        win_found_s = 1'b1;
        win_id_s    = scan_idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Only the winner sees ready, and only when the stage can take a new write.
  always_comb begin
    ready_s = '0;
    if (xfer_s) begin
      ready_s[win_id_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  // Next-state for the output stage and round-robin pointer.
  always_comb begin
    stage_vld_d  = stage_vld_q;
    stage_addr_d = stage_addr_q;
    stage_data_d = stage_data_q;
    stage_id_d   = stage_id_q;
    rr_ptr_d     = rr_ptr_q;
    if (xfer_s) begin
      stage_vld_d  = 1'b1;
      stage_addr_d = bus.req_addr[win_id_s*ADDR_W +: ADDR_W];
      stage_data_d = bus.req_data[win_id_s*DATA_W +: DATA_W];
      stage_id_d   = win_id_s;
      rr_ptr_d     = (win_id_s == ID_W'(NREQ - 1)) ? '0 : win_id_s + ID_W'(1);
    end else if (drain_s) begin
      stage_vld_d  = 1'b0;
    end else begin
      stage_vld_d  = stage_vld_q;
    end
  end

  // Stage and pointer registers; reset discards any pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_vld_q  <= 1'b0;
      stage_addr_q <= '0;
      stage_data_q <= '0;
      stage_id_q   <= '0;
      rr_ptr_q     <= '0;
    end else begin
      stage_vld_q  <= stage_vld_d;
      stage_addr_q <= stage_addr_d;
      stage_data_q <= stage_data_d;
      stage_id_q   <= stage_id_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  // Writes to x0 occupy the stage but never reach the regfile.
  assign bus.wr_en     = stage_vld_q & (stage_addr_q != '0) & ~bus.wb_stall;
  assign bus.wr_addr   = stage_addr_q;
  assign bus.wr_data   = stage_data_q;
  assign bus.grant_id  = stage_id_q;
  assign bus.busy      = stage_vld_q;
  assign bus.req_ready = ready_s;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector table for a 2-requester arbiter plus a scoreboarded
// random-stall run on a 3-requester instance.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NREQ(2), .ADDR_W(5), .DATA_W(32)) bus2 ();
  regfile_wb_arbiter_if #(.NREQ(3), .ADDR_W(5), .DATA_W(32)) bus3 ();

  regfile_wb_arbiter #(.NREQ(2), .ADDR_W(5), .DATA_W(32)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave));
  regfile_wb_arbiter #(.NREQ(3), .ADDR_W(5), .DATA_W(32)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave));

  typedef struct {
    logic [1:0]  v;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        st;
    logic [1:0]  rdy;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        gid;
    logic        busy;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  function automatic vec_t mk(logic [1:0] v, logic [4:0] a0, logic [4:0] a1,
                              logic [31:0] d0, logic [31:0] d1, logic st,
                              logic [1:0] rdy, logic wen, logic [4:0] wa,
                              logic [31:0] wd, logic gid, logic busy);
    vec_t r;
    r.v = v; r.a0 = a0; r.a1 = a1; r.d0 = d0; r.d1 = d1; r.st = st;
    r.rdy = rdy; r.wen = wen; r.wa = wa; r.wd = wd; r.gid = gid; r.busy = busy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] addr_of(int i, int s);
    return 5'(i * 8 + (s % 7) + 1);
  endfunction

  function automatic logic [31:0] data_of(int i, int s);
    return {8'(i), 24'(s)};
  endfunction

  // Reference model state for the 3-requester run
  logic        m_vld;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_id, m_rr;
  int          acc_seq [3];
  int          drn_seq [3];

  initial begin
    logic        stall;
    logic        can;
    logic [2:0]  exp_rdy;
    int          mx, mn;

    // Stimulus table: outputs expected during the cycle the inputs are applied
    vecs[0]  = mk(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 2'b01, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0);
    vecs[1]  = mk(2'b10, 5'd0, 5'd0, 32'h0, 32'h1234,     1'b0, 2'b10, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1);
    vecs[2]  = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0,        1'b0, 2'b00, 1'b0, 5'd0, 32'h1234,     1'b1, 1'b1);
    vecs[3]  = mk(2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 1'b0, 2'b01, 1'b0, 5'd0, 32'h1234,     1'b1, 1'b0);
    vecs[4]  = mk(2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 1'b0, 2'b10, 1'b1, 5'd1, 32'h11111111, 1'b0, 1'b1);
    vecs[5]  = mk(2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 1'b0, 2'b01, 1'b1, 5'd2, 32'h22222222, 1'b1, 1'b1);
    vecs[6]  = mk(2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 1'b0, 2'b10, 1'b1, 5'd1, 32'h11111111, 1'b0, 1'b1);
    vecs[7]  = mk(2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 1'b0, 2'b01, 1'b1, 5'd2, 32'h22222222, 1'b1, 1'b1);
    vecs[8]  = mk(2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 1'b0, 2'b10, 1'b1, 5'd1, 32'h11111111, 1'b0, 1'b1);
    vecs[9]  = mk(2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 1'b1, 2'b00, 1'b0, 5'd2, 32'h22222222, 1'b1, 1'b1);
    vecs[10] = mk(2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 1'b1, 2'b00, 1'b0, 5'd2, 32'h22222222, 1'b1, 1'b1);
    vecs[11] = mk(2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 1'b1, 2'b00, 1'b0, 5'd2, 32'h22222222, 1'b1, 1'b1);
    vecs[12] = mk(2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 1'b0, 2'b01, 1'b1, 5'd2, 32'h22222222, 1'b1, 1'b1);
    vecs[13] = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0,        1'b0, 2'b00, 1'b1, 5'd1, 32'h11111111, 1'b0, 1'b1);
    vecs[14] = mk(2'b01, 5'd3, 5'd0, 32'h33333333, 32'h0, 1'b1, 2'b01, 1'b0, 5'd1, 32'h11111111, 1'b0, 1'b0);
    vecs[15] = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0,        1'b1, 2'b00, 1'b0, 5'd3, 32'h33333333, 1'b0, 1'b1);

    reset = 1'b1;
    bus2.req_valid = 2'b01; bus2.req_addr = 10'd5; bus2.req_data = 64'hDEADBEEF;
    bus2.wb_stall = 1'b0;
    bus3.req_valid = 3'b000; bus3.req_addr = '0; bus3.req_data = '0; bus3.wb_stall = 1'b0;

    @(negedge clk); #2;
    chk("rst_ready", 64'(bus2.req_ready), 64'h0);
    chk("rst_wr_en", 64'(bus2.wr_en),     64'h0);
    chk("rst_busy",  64'(bus2.busy),      64'h0);
    chk("rst_addr",  64'(bus2.wr_addr),   64'h0);
    chk("rst_data",  64'(bus2.wr_data),   64'h0);
    chk("rst_gid",   64'(bus2.grant_id),  64'h0);
    bus2.req_valid = 2'b00;
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus2.req_valid = vecs[i].v;
      bus2.req_addr  = {vecs[i].a1, vecs[i].a0};
      bus2.req_data  = {vecs[i].d1, vecs[i].d0};
      bus2.wb_stall  = vecs[i].st;
      #2;
      chk($sformatf("v%0d_ready", i), 64'(bus2.req_ready), 64'(vecs[i].rdy));
      chk($sformatf("v%0d_wr_en", i), 64'(bus2.wr_en),     64'(vecs[i].wen));
      chk($sformatf("v%0d_addr", i),  64'(bus2.wr_addr),   64'(vecs[i].wa));
      chk($sformatf("v%0d_data", i),  64'(bus2.wr_data),   64'(vecs[i].wd));
      chk($sformatf("v%0d_gid", i),   64'(bus2.grant_id),  64'(vecs[i].gid));
      chk($sformatf("v%0d_busy", i),  64'(bus2.busy),      64'(vecs[i].busy));
    end

    // Async reset while the stage is full and stalled
    @(negedge clk);
    bus2.req_valid = 2'b11;
    bus2.req_addr  = {5'd9, 5'd7};
    bus2.req_data  = {32'h99999999, 32'h77777777};
    bus2.wb_stall  = 1'b1;
    #2;
    chk("t5_pre_busy",  64'(bus2.busy),      64'h1);
    chk("t5_pre_ready", 64'(bus2.req_ready), 64'h0);
    #1 reset = 1'b1;
    #1;
    chk("t5_rst_wr_en", 64'(bus2.wr_en),     64'h0);
    chk("t5_rst_busy",  64'(bus2.busy),      64'h0);
    chk("t5_rst_ready", 64'(bus2.req_ready), 64'h0);
    chk("t5_rst_addr",  64'(bus2.wr_addr),   64'h0);
    @(negedge clk);
    reset = 1'b0;
    bus2.wb_stall = 1'b0;
    #2;
    chk("t5_post_ready", 64'(bus2.req_ready), 64'h1);
    @(negedge clk);
    bus2.req_valid = 2'b00;
    #2;
    chk("t5_post_wr_en", 64'(bus2.wr_en),    64'h1);
    chk("t5_post_addr",  64'(bus2.wr_addr),  64'h7);
    chk("t5_post_data",  64'(bus2.wr_data),  64'h77777777);
    chk("t5_post_gid",   64'(bus2.grant_id), 64'h0);

    // Three requesters always valid, random stall, checked against a model
    m_vld = 1'b0; m_addr = '0; m_data = '0; m_id = 0; m_rr = 0;
    for (int i = 0; i < 3; i++) begin
      acc_seq[i] = 0;
      drn_seq[i] = 0;
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      stall = 1'($urandom_range(0, 1));
      bus3.wb_stall  = stall;
      bus3.req_valid = 3'b111;
      for (int i = 0; i < 3; i++) begin
        bus3.req_addr[i*5 +: 5]   = addr_of(i, acc_seq[i]);
        bus3.req_data[i*32 +: 32] = data_of(i, acc_seq[i]);
      end
      #2;
      can     = ~m_vld | ~stall;
      exp_rdy = can ? 3'(1 << m_rr) : 3'b000;
      chk($sformatf("r3_c%0d_ready", c), 64'(bus3.req_ready), 64'(exp_rdy));
      chk($sformatf("r3_c%0d_wr_en", c), 64'(bus3.wr_en),     64'(m_vld & ~stall));
      chk($sformatf("r3_c%0d_busy", c),  64'(bus3.busy),      64'(m_vld));
      if (m_vld) begin
        chk($sformatf("r3_c%0d_gid", c),  64'(bus3.grant_id), 64'(m_id));
        chk($sformatf("r3_c%0d_addr", c), 64'(bus3.wr_addr),  64'(m_addr));
        chk($sformatf("r3_c%0d_data", c), 64'(bus3.wr_data),  64'(m_data));
        if (!stall) begin
          chk($sformatf("r3_c%0d_order", c), 64'(bus3.wr_data),
              64'(data_of(m_id, drn_seq[m_id])));
          drn_seq[m_id]++;
        end
      end
      if (can) begin
        m_vld  = 1'b1;
        m_addr = addr_of(m_rr, acc_seq[m_rr]);
        m_data = data_of(m_rr, acc_seq[m_rr]);
        m_id   = m_rr;
        acc_seq[m_rr]++;
        m_rr   = (m_rr + 1) % 3;
      end else if (m_vld && !stall) begin
        m_vld = 1'b0;
      end
    end
    @(negedge clk);
    bus3.req_valid = 3'b000;
    mx = acc_seq[0]; mn = acc_seq[0];
    for (int i = 1; i < 3; i++) begin
      if (acc_seq[i] > mx) mx = acc_seq[i];
      if (acc_seq[i] < mn) mn = acc_seq[i];
    end
    chk("r3_fair_spread", 64'(mx - mn <= 1), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
